// File: rtl/ddnf_dknf_13_8.sv
// ddnf_dknf_13_8: one fixed 13-in / 8-out truth table realised twice.
// The DDNF path is a sum of minterms and the DKNF path is a product of maxterms.
// Both results are registered side by side with a registered disagreement flag.
// Table word: f(n) = (n[7:0] + n[12:8]) mod 256; o_y[0] carries f bit 7.

module ddnf_dknf_13_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] i_x,
    output logic [0:7]  o_y_ddnf,
    output logic [0:7]  o_y_dknf,
    output logic        o_mismatch
);

    localparam int unsigned N_ENTRIES = 8192;

    // The table word for index n. It is only ever called with the loop constant,
    // so after unrolling it folds to a constant per term. No adder touches i_x.
    function automatic logic [7:0] table_word(input logic [12:0] n);
        return n[7:0] + {3'b000, n[12:8]};
    endfunction

    logic [7:0]  ddnf_comb;
    logic [7:0]  dknf_comb;
    logic [12:0] dd_idx;
    logic [7:0]  dd_word;
    logic        dd_minterm;
    logic [12:0] dk_idx;
    logic [7:0]  dk_word;
    logic        dk_maxterm;

    // Sum of minterms: each output bit ORs the minterms of the indices where that bit is 1.
    // XNOR against the constant index selects i_x[j] or ~i_x[j] as literal j.
    always_comb begin
        ddnf_comb  = '0;
        dd_idx     = '0;
        dd_word    = '0;
        dd_minterm = 1'b0;
        for (int unsigned n = 0; n < N_ENTRIES; n++) begin
            dd_idx     = 13'(n);
            dd_word    = table_word(dd_idx);
            dd_minterm = &(i_x ~^ dd_idx);
            ddnf_comb  = ddnf_comb | (dd_word & {8{dd_minterm}});
        end
    end

    // Product of maxterms: each output bit ANDs the maxterms of the indices where that bit is 0.
    // XOR against the constant index selects ~i_x[j] or i_x[j] as literal j.
    always_comb begin
        dknf_comb  = '1;
        dk_idx     = '0;
        dk_word    = '0;
        dk_maxterm = 1'b1;
        for (int unsigned n = 0; n < N_ENTRIES; n++) begin
            dk_idx     = 13'(n);
            dk_word    = table_word(dk_idx);
            dk_maxterm = |(i_x ^ dk_idx);
            dknf_comb  = dknf_comb & (dk_word | {8{dk_maxterm}});
        end
    end

    // Register both realisations and their disagreement. Bit 7 of each word lands on o_y[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_y_ddnf   <= '0;
            o_y_dknf   <= '0;
            o_mismatch <= 1'b0;
        end else begin
            o_y_ddnf   <= ddnf_comb;
            o_y_dknf   <= dknf_comb;
            o_mismatch <= (ddnf_comb != dknf_comb);
        end
    end

endmodule

// File: tb/tb_ddnf_dknf_13_8.sv
// Testbench for ddnf_dknf_13_8. A scoreboard queue holds the expected words.

module tb_ddnf_dknf_13_8;

    logic        clk;
    logic        rst_n;
    logic [12:0] i_x;
    logic [0:7]  o_y_ddnf;
    logic [0:7]  o_y_dknf;
    logic        o_mismatch;

    int unsigned errors;
    int unsigned checks;
    logic [7:0]  sb[$];
    logic [7:0]  exp_w;

    ddnf_dknf_13_8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_x        (i_x),
        .o_y_ddnf   (o_y_ddnf),
        .o_y_dknf   (o_y_dknf),
        .o_mismatch (o_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: low byte plus the top five bits, wrapped to 8 bits.
    function automatic logic [7:0] ref_f(input int n);
        int s;
        s = (n % 256) + (n / 256);
        return 8'(s % 256);
    endfunction

    // Apply a value and record what it must produce one edge later.
    task automatic drive(input logic [12:0] x, input logic [7:0] e);
        i_x = x;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_x   = 13'h1FFF;
        #2;
        checks++; if (o_y_ddnf !== 8'h00) begin errors++; $display("FAIL reset_ddnf: got %h expected 00", o_y_ddnf); end
        checks++; if (o_y_dknf !== 8'h00) begin errors++; $display("FAIL reset_dknf: got %h expected 00", o_y_dknf); end
        checks++; if (o_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b expected 0", o_mismatch); end
        i_x = 13'h0000;
        @(posedge clk); #1;
        i_x = 13'h1FFF;
        @(posedge clk); #1;
        checks++; if (o_y_ddnf !== 8'h00) begin errors++; $display("FAIL reset_hold_ddnf: got %h expected 00", o_y_ddnf); end
        checks++; if (o_y_dknf !== 8'h00) begin errors++; $display("FAIL reset_hold_dknf: got %h expected 00", o_y_dknf); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(13'h1FFF, 8'h1E);
        @(posedge clk); #1;
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL reset_release_sb: got empty queue expected entry"); end
        else begin
            exp_w = sb.pop_front();
            checks++; if (o_y_ddnf !== exp_w) begin errors++; $display("FAIL release_ddnf: got %h expected %h", o_y_ddnf, exp_w); end
            checks++; if (o_y_dknf !== exp_w) begin errors++; $display("FAIL release_dknf: got %h expected %h", o_y_dknf, exp_w); end
            checks++; if (o_mismatch !== 1'b0) begin errors++; $display("FAIL release_mismatch: got %b expected 0", o_mismatch); end
        end
    endtask

    task automatic test_sweep();
        for (int n = 0; n < 8192; n++) begin
            drive(13'(n), ref_f(n));
            @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL sweep_sb: got empty queue expected entry at n=%0d", n); end
            else begin
                exp_w = sb.pop_front();
                checks++; if (o_y_ddnf !== exp_w) begin errors++; $display("FAIL sweep_ddnf n=%0d: got %h expected %h", n, o_y_ddnf, exp_w); end
                checks++; if (o_y_dknf !== exp_w) begin errors++; $display("FAIL sweep_dknf n=%0d: got %h expected %h", n, o_y_dknf, exp_w); end
                checks++; if (o_mismatch !== 1'b0) begin errors++; $display("FAIL sweep_mismatch n=%0d: got %b expected 0", n, o_mismatch); end
            end
        end
    endtask

    task automatic test_directed();
        logic [12:0] xs [5];
        logic [7:0]  es [5];
        xs = '{13'h0000, 13'h00FF, 13'h0100, 13'h01FF, 13'h1F05};
        es = '{8'h00,    8'hFF,    8'h01,    8'h00,    8'h24};
        for (int i = 0; i < 5; i++) begin
            drive(xs[i], es[i]);
            @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL directed_sb: got empty queue expected entry"); end
            else begin
                exp_w = sb.pop_front();
                checks++; if (o_y_ddnf !== exp_w) begin errors++; $display("FAIL directed_ddnf x=%h: got %h expected %h", xs[i], o_y_ddnf, exp_w); end
                checks++; if (o_y_dknf !== exp_w) begin errors++; $display("FAIL directed_dknf x=%h: got %h expected %h", xs[i], o_y_dknf, exp_w); end
            end
        end
    endtask

    task automatic test_bit_order();
        drive(13'h0001, 8'h01);
        @(posedge clk); #1;
        void'(sb.pop_front());
        checks++; if (o_y_ddnf[7] !== 1'b1 || o_y_ddnf[0:6] !== 7'b0) begin errors++; $display("FAIL bitorder_ddnf: got %b expected 00000001 in [0:7] order", o_y_ddnf); end
        checks++; if (o_y_dknf[7] !== 1'b1 || o_y_dknf[0:6] !== 7'b0) begin errors++; $display("FAIL bitorder_dknf: got %b expected 00000001 in [0:7] order", o_y_dknf); end
    endtask

    task automatic test_async_reset();
        drive(13'h00FF, 8'hFF);
        @(posedge clk); #1;
        void'(sb.pop_front());
        @(posedge clk); #1;
        checks++; if (o_y_ddnf !== 8'hFF) begin errors++; $display("FAIL async_pre_ddnf: got %h expected ff", o_y_ddnf); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (o_y_ddnf !== 8'h00) begin errors++; $display("FAIL async_ddnf: got %h expected 00", o_y_ddnf); end
        checks++; if (o_y_dknf !== 8'h00) begin errors++; $display("FAIL async_dknf: got %h expected 00", o_y_dknf); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(13'h00FF, 8'hFF);
        @(posedge clk); #1;
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL async_sb: got empty queue expected entry"); end
        else begin
            exp_w = sb.pop_front();
            checks++; if (o_y_ddnf !== exp_w) begin errors++; $display("FAIL async_release_ddnf: got %h expected %h", o_y_ddnf, exp_w); end
            checks++; if (o_y_dknf !== exp_w) begin errors++; $display("FAIL async_release_dknf: got %h expected %h", o_y_dknf, exp_w); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) drive(13'h0000, 8'h00);
            else            drive(13'h00FF, 8'hFF);
            @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL b2b_sb: got empty queue expected entry"); end
            else begin
                exp_w = sb.pop_front();
                checks++; if (o_y_ddnf !== exp_w) begin errors++; $display("FAIL b2b_ddnf i=%0d: got %h expected %h", i, o_y_ddnf, exp_w); end
                checks++; if (o_y_dknf !== exp_w) begin errors++; $display("FAIL b2b_dknf i=%0d: got %h expected %h", i, o_y_dknf, exp_w); end
                checks++; if (o_mismatch !== 1'b0) begin errors++; $display("FAIL b2b_mismatch i=%0d: got %b expected 0", i, o_mismatch); end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        i_x    = '0;
        test_reset();
        test_sweep();
        test_directed();
        test_bit_order();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
